hazard_scoreboard_unit: RTL and testbench



---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_scoreboard.sv | 53 +++++
 rtl/hazard_scoreboard_unit.sv | 138 +++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard unit
// Contents: forwarding select encoding, load result-source code, MD FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register pending-write scoreboard for the MD unit
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   clr_en, clr_rd        MD completion clears busy[clr_rd] (also bypassed to reads)
//   set_en, set_rd        MD issue marks busy[set_rd] (x0 never marked)
//   rs1, rs2, rd          read addresses
//   busy_rs1/rs2/rd       effective busy bits for the read addresses
module hazard_scoreboard #(
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_rd,
  input  logic          set_en,
  input  logic [AW-1:0] set_rd,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] rd,
  output logic          busy_rs1,
  output logic          busy_rs2,
  output logic          busy_rd
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] eff_busy;
  logic [NREGS-1:0] busy_nxt;

  // The register file is write-first, so a completing MD result is already
  // readable in its done cycle; the clear is visible to readers immediately.
  always_comb begin
    eff_busy = busy;
    if (clr_en) eff_busy[clr_rd] = 1'b0;
  end

  // Clear then set: a back-to-back issue to the same register keeps it busy.
  always_comb begin
    busy_nxt = eff_busy;
    if (set_en && set_rd != '0) busy_nxt[set_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign busy_rs1 = eff_busy[rs1];
  assign busy_rs2 = eff_busy[rs2];
  assign busy_rd  = eff_busy[rd];

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - 5-stage pipeline hazard unit with MD scoreboard
// Ports:
//   decode  : rs1_d rs2_d rd_d uses_rs1_d uses_rs2_d reg_write_d md_d
//   execute : rs1_x rs2_x rd_x result_src_x pc_src_x md_issue_x
//   memory  : rd_m rs2_m reg_write_m mem_write_m
//   wb      : rd_w reg_write_w
//   MD unit : md_done md_rd
//   perf    : perf_clr (sync clear), stall_cycles, flush_count (saturating)
//   control : stall_f stall_d flush_d flush_x forward_a_x forward_b_x
//             forward_store_m md_busy
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int CNT_W = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rs1_d,
  input  logic [AW-1:0]    rs2_d,
  input  logic [AW-1:0]    rd_d,
  input  logic             uses_rs1_d,
  input  logic             uses_rs2_d,
  input  logic             reg_write_d,
  input  logic             md_d,
  input  logic [AW-1:0]    rs1_x,
  input  logic [AW-1:0]    rs2_x,
  input  logic [AW-1:0]    rd_x,
  input  logic [1:0]       result_src_x,
  input  logic             pc_src_x,
  input  logic             md_issue_x,
  input  logic [AW-1:0]    rd_m,
  input  logic [AW-1:0]    rs2_m,
  input  logic             reg_write_m,
  input  logic             mem_write_m,
  input  logic [AW-1:0]    rd_w,
  input  logic             reg_write_w,
  input  logic             md_done,
  input  logic [AW-1:0]    md_rd,
  input  logic             perf_clr,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_x,
  output logic [1:0]       forward_a_x,
  output logic [1:0]       forward_b_x,
  output logic             forward_store_m,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  md_state_t state, state_nxt;
  logic      md_busy_int;
  logic      sb_rs1, sb_rs2, sb_rd;
  logic      load_stall, sb_stall, hazard, stall_int;

  hazard_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .clr_en   (md_done),
    .clr_rd   (md_rd),
    .set_en   (md_issue_x),
    .set_rd   (rd_x),
    .rs1      (rs1_d),
    .rs2      (rs2_d),
    .rd       (rd_d),
    .busy_rs1 (sb_rs1),
    .busy_rs2 (sb_rs2),
    .busy_rd  (sb_rd)
  );

  // M is younger than W, so it wins when both write the same register.
  function automatic fwd_sel_t fwd_sel(input logic [AW-1:0] rs,
                                       input logic [AW-1:0] dm, input logic wm,
                                       input logic [AW-1:0] dw, input logic ww);
    if (rs != '0 && wm && rs == dm)      return FWD_M;
    else if (rs != '0 && ww && rs == dw) return FWD_W;
    else                                 return FWD_RF;
  endfunction

  assign load_stall = (result_src_x == RESULT_LOAD) && (rd_x != '0) &&
                      ((uses_rs1_d && rs1_d == rd_x) || (uses_rs2_d && rs2_d == rd_x));

  // The rd term is the WAW guard; the md_d term holds a second MD op until
  // the unit frees up (a done cycle frees it for a same-cycle reissue).
  assign sb_stall = (uses_rs1_d && sb_rs1) || (uses_rs2_d && sb_rs2) ||
                    (reg_write_d && sb_rd) || (md_d && md_busy_int && !md_done);

  assign hazard    = load_stall || sb_stall;
  // A redirect means the D instruction is wrong-path; flushing beats stalling.
  assign stall_int = hazard && !pc_src_x;

  assign stall_f         = !rst && stall_int;
  assign stall_d         = !rst && stall_int;
  assign flush_d         = !rst && pc_src_x;
  assign flush_x         = !rst && (hazard || pc_src_x);
  assign forward_a_x     = rst ? 2'b00 : fwd_sel(rs1_x, rd_m, reg_write_m, rd_w, reg_write_w);
  assign forward_b_x     = rst ? 2'b00 : fwd_sel(rs2_x, rd_m, reg_write_m, rd_w, reg_write_w);
  assign forward_store_m = !rst && mem_write_m && reg_write_w && rd_w != '0 && rs2_m == rd_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nxt;
  end

  // A done in IDLE is ignored; an issue while BUSY without done cannot
  // happen legally and simply leaves the FSM BUSY.
  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (md_issue_x)             state_nxt = MD_BUSY;
      MD_BUSY: if (md_done && !md_issue_x) state_nxt = MD_IDLE;
      default:                             state_nxt = MD_IDLE;
    endcase
  end

  always_comb begin
    md_busy_int = (state == MD_BUSY);
  end

  assign md_busy = !rst && md_busy_int;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_int && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
      if (pc_src_x && flush_count != '1)   flush_count  <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - self-checking bench for hazard_scoreboard_unit
module tb_hazard_scoreboard_unit;

  localparam int CW  = 4;
  localparam int MAX = 15;

  logic clk = 0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs1_d, rs2_d, rd_d, rs1_x, rs2_x, rd_x, rd_m, rs2_m, rd_w, md_rd;
  logic       uses_rs1_d, uses_rs2_d, reg_write_d, md_d, pc_src_x, md_issue_x;
  logic [1:0] result_src_x;
  logic       reg_write_m, mem_write_m, reg_write_w, md_done, perf_clr;
  logic       stall_f, stall_d, flush_d, flush_x, forward_store_m, md_busy;
  logic [1:0] forward_a_x, forward_b_x;
  logic [CW-1:0] stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;

  // reference state: set of registers awaiting an MD result, op outstanding flag
  bit pend[32];
  bit md_out;
  int m_stall, m_flush;

  hazard_scoreboard_unit #(.NREGS(32), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d), .reg_write_d(reg_write_d), .md_d(md_d),
    .rs1_x(rs1_x), .rs2_x(rs2_x), .rd_x(rd_x), .result_src_x(result_src_x),
    .pc_src_x(pc_src_x), .md_issue_x(md_issue_x),
    .rd_m(rd_m), .rs2_m(rs2_m), .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w),
    .md_done(md_done), .md_rd(md_rd), .perf_clr(perf_clr),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_x(flush_x),
    .forward_a_x(forward_a_x), .forward_b_x(forward_b_x),
    .forward_store_m(forward_store_m), .md_busy(md_busy),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic clear_inputs();
    rs1_d = 0; rs2_d = 0; rd_d = 0; rs1_x = 0; rs2_x = 0; rd_x = 0;
    rd_m = 0; rs2_m = 0; rd_w = 0; md_rd = 0;
    uses_rs1_d = 0; uses_rs2_d = 0; reg_write_d = 0; md_d = 0;
    pc_src_x = 0; md_issue_x = 0; result_src_x = 0;
    reg_write_m = 0; mem_write_m = 0; reg_write_w = 0; md_done = 0; perf_clr = 0;
  endtask

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 0;
    md_out = 0; m_stall = 0; m_flush = 0;
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (rs != 0 && reg_write_m && rs == rd_m) return 2'b10;
    if (rs != 0 && reg_write_w && rs == rd_w) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit waiting(input logic [4:0] r);
    return pend[r] && !(md_done && md_rd == r);
  endfunction

  function automatic bit exp_hazard();
    bit ld, sb;
    ld = result_src_x == 2'b01 && rd_x != 0 &&
         ((uses_rs1_d && rs1_d == rd_x) || (uses_rs2_d && rs2_d == rd_x));
    sb = (uses_rs1_d && waiting(rs1_d)) || (uses_rs2_d && waiting(rs2_d)) ||
         (reg_write_d && waiting(rd_d)) || (md_d && md_out && !md_done);
    return ld || sb;
  endfunction

  function automatic bit exp_stall();
    return exp_hazard() && !pc_src_x;
  endfunction

  // advance one clock; reference state follows the edge; returns at negedge
  task automatic tick();
    bit s;
    s = exp_stall();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (md_done) pend[md_rd] = 0;
      if (md_issue_x && rd_x != 0) pend[rd_x] = 1;
      if (!md_out && md_issue_x) md_out = 1;
      else if (md_out && md_done && !md_issue_x) md_out = 0;
      if (perf_clr) begin m_stall = 0; m_flush = 0; end
      else begin
        if (s && m_stall < MAX) m_stall++;
        if (pc_src_x && m_flush < MAX) m_flush++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    rd_m = 5; reg_write_m = 1; rs1_x = 5; rs2_x = 5; pc_src_x = 1;
    result_src_x = 2'b01; rd_x = 3; rs1_d = 3; uses_rs1_d = 1;
    mem_write_m = 1; reg_write_w = 1; rd_w = 4; rs2_m = 4; md_issue_x = 1; rd_x = 3;
    #1;
    checks++;
    if ({stall_f, stall_d, flush_d, flush_x, forward_a_x, forward_b_x, forward_store_m, md_busy} !== 10'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0", {stall_f, stall_d, flush_d, flush_x, forward_a_x, forward_b_x, forward_store_m, md_busy});
    end
    tick();
    checks++;
    if (md_busy !== 1'b0 || stall_cycles !== 0 || flush_count !== 0) begin
      errors++; $display("FAIL reset_state got busy=%b st=%0d fl=%0d want 0 0 0", md_busy, stall_cycles, flush_count);
    end
    clear_inputs();
    rst = 0;
    model_reset();
    tick();
  endtask

  task automatic test_forwarding();
    rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1; rs1_x = 5; rs2_x = 5; #1;
    checks++; if (forward_a_x !== 2'b10) begin errors++; $display("FAIL fwd_a_m got %b want 10", forward_a_x); end
    checks++; if (forward_b_x !== 2'b10) begin errors++; $display("FAIL fwd_b_m got %b want 10", forward_b_x); end
    reg_write_m = 0; #1;
    checks++; if (forward_a_x !== 2'b01) begin errors++; $display("FAIL fwd_a_w got %b want 01", forward_a_x); end
    rs1_x = 0; reg_write_m = 1; rd_m = 0; rd_w = 0; #1;
    checks++; if (forward_a_x !== 2'b00) begin errors++; $display("FAIL fwd_a_x0 got %b want 00", forward_a_x); end
    rs2_m = 6; rd_w = 6; mem_write_m = 1; reg_write_w = 1; #1;
    checks++; if (forward_store_m !== 1'b1) begin errors++; $display("FAIL fwd_store got %b want 1", forward_store_m); end
    rs2_m = 0; rd_w = 0; #1;
    checks++; if (forward_store_m !== 1'b0) begin errors++; $display("FAIL fwd_store_x0 got %b want 0", forward_store_m); end
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    result_src_x = 2'b01; rd_x = 7; rs2_d = 7; uses_rs2_d = 1; #1;
    checks++;
    if ({stall_f, stall_d, flush_x, flush_d} !== 4'b1110) begin
      errors++; $display("FAIL load_use got %b want 1110", {stall_f, stall_d, flush_x, flush_d});
    end
    tick();
    result_src_x = 2'b00; rd_x = 0; #1;   // load moved on, bubble in X
    checks++;
    if (stall_d !== 1'b0) begin errors++; $display("FAIL load_use_len got %b want 0", stall_d); end
    result_src_x = 2'b01; rd_x = 7; uses_rs2_d = 0; #1;
    checks++;
    if ({stall_d, flush_x} !== 2'b00) begin errors++; $display("FAIL load_nouse got %b want 00", {stall_d, flush_x}); end
    clear_inputs();
    tick();
  endtask

  task automatic test_redirect();
    perf_clr = 1;
    tick();
    perf_clr = 0;
    result_src_x = 2'b01; rd_x = 7; rs1_d = 7; uses_rs1_d = 1; pc_src_x = 1; #1;
    checks++;
    if ({stall_f, stall_d, flush_d, flush_x} !== 4'b0011) begin
      errors++; $display("FAIL redirect got %b want 0011", {stall_f, stall_d, flush_d, flush_x});
    end
    tick();
    clear_inputs(); #1;
    checks++;
    if (flush_count !== 1 || stall_cycles !== 0) begin
      errors++; $display("FAIL redirect_cnt got fl=%0d st=%0d want 1 0", flush_count, stall_cycles);
    end
  endtask

  task automatic test_md_raw();
    perf_clr = 1;
    tick();
    perf_clr = 0;
    md_issue_x = 1; rd_x = 9;
    tick();
    md_issue_x = 0; rd_x = 0; rs1_d = 9; uses_rs1_d = 1;
    for (int c = 1; c <= 10; c++) begin
      if (c == 10) begin md_done = 1; md_rd = 9; end
      #1;
      checks++;
      if (stall_d !== (c < 10)) begin errors++; $display("FAIL md_stall_c%0d got %b want %b", c, stall_d, c < 10); end
      checks++;
      if (md_busy !== 1'b1) begin errors++; $display("FAIL md_busy_c%0d got %b want 1", c, md_busy); end
      tick();
    end
    clear_inputs(); #1;
    checks++;
    if (md_busy !== 1'b0 || stall_cycles !== 9) begin
      errors++; $display("FAIL md_after got busy=%b st=%0d want 0 9", md_busy, stall_cycles);
    end
    // WAW: a write to a pending register stalls too
    md_issue_x = 1; rd_x = 11;
    tick();
    md_issue_x = 0; rd_x = 0; rd_d = 11; reg_write_d = 1; #1;
    checks++;
    if (stall_d !== 1'b1) begin errors++; $display("FAIL md_waw got %b want 1", stall_d); end
    md_done = 1; md_rd = 11;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    md_issue_x = 1; rd_x = 9;
    tick();
    md_done = 1; md_rd = 9;     // done and reissue to the same register
    tick();
    md_done = 0; md_issue_x = 0; rd_x = 0; rs1_d = 9; uses_rs1_d = 1; #1;
    checks++;
    if (stall_d !== 1'b1 || md_busy !== 1'b1) begin
      errors++; $display("FAIL b2b got stall=%b busy=%b want 1 1", stall_d, md_busy);
    end
    uses_rs1_d = 0; md_d = 1; #1;
    checks++;
    if (stall_d !== 1'b1) begin errors++; $display("FAIL md_struct got %b want 1", stall_d); end
    md_done = 1; md_rd = 9; #1;
    checks++;
    if (stall_d !== 1'b0) begin errors++; $display("FAIL md_struct_done got %b want 0", stall_d); end
    md_d = 0;
    tick();
    clear_inputs(); #1;
    checks++;
    if (md_busy !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", md_busy); end
  endtask

  task automatic test_saturation();
    perf_clr = 1;
    tick();
    perf_clr = 0;
    result_src_x = 2'b01; rd_x = 3; rs1_d = 3; uses_rs1_d = 1;
    repeat (20) tick();
    #1;
    checks++;
    if (stall_cycles !== 4'd15) begin errors++; $display("FAIL sat got %0d want 15", stall_cycles); end
    perf_clr = 1;   // clear beats the stall seen in the same cycle
    tick();
    #1;
    checks++;
    if (stall_cycles !== 0) begin errors++; $display("FAIL perf_clr got %0d want 0", stall_cycles); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_md();
    md_issue_x = 1; rd_x = 12; pc_src_x = 1;
    tick();
    clear_inputs(); #1;
    checks++;
    if (md_busy !== 1'b1) begin errors++; $display("FAIL pre_rst got %b want 1", md_busy); end
    rst = 1; #1;
    checks++;
    if (md_busy !== 1'b0 || flush_count !== 0) begin
      errors++; $display("FAIL async_rst got busy=%b fl=%0d want 0 0", md_busy, flush_count);
    end
    tick();
    rst = 0;
    rs1_d = 12; uses_rs1_d = 1; #1;
    checks++;
    if (stall_d !== 1'b0) begin errors++; $display("FAIL rst_sb got %b want 0", stall_d); end
    md_done = 1; md_rd = 12;    // late completion of the discarded op
    tick();
    clear_inputs(); #1;
    checks++;
    if (md_busy !== 1'b0) begin errors++; $display("FAIL late_done got %b want 0", md_busy); end
  endtask

  task automatic test_random();
    logic [4:0] md_dest;
    md_dest = 0;
    for (int n = 0; n < 400; n++) begin
      rs1_d = 5'($urandom_range(0, 7)); rs2_d = 5'($urandom_range(0, 7)); rd_d = 5'($urandom_range(0, 7));
      rs1_x = 5'($urandom_range(0, 7)); rs2_x = 5'($urandom_range(0, 7)); rd_x = 5'($urandom_range(0, 7));
      rd_m = 5'($urandom_range(0, 7)); rs2_m = 5'($urandom_range(0, 7)); rd_w = 5'($urandom_range(0, 7));
      uses_rs1_d = 1'($urandom); uses_rs2_d = 1'($urandom); reg_write_d = 1'($urandom);
      md_d = ($urandom_range(0, 3) == 0);
      result_src_x = 2'($urandom);
      pc_src_x = ($urandom_range(0, 4) == 0);
      reg_write_m = 1'($urandom); mem_write_m = 1'($urandom); reg_write_w = 1'($urandom);
      perf_clr = ($urandom_range(0, 15) == 0);
      if (md_out) begin
        md_done = ($urandom_range(0, 3) == 0);
        md_rd = md_dest;
        md_issue_x = md_done && ($urandom_range(0, 1) == 0);
      end else begin
        md_done = ($urandom_range(0, 15) == 0);
        md_rd = 5'($urandom_range(0, 7));
        md_issue_x = ($urandom_range(0, 3) == 0);
      end
      if (md_issue_x) md_dest = rd_x;
      #1;
      checks++;
      if (forward_a_x !== exp_fwd(rs1_x) || forward_b_x !== exp_fwd(rs2_x)) begin
        errors++; $display("FAIL rnd_fwd n=%0d got %b/%b want %b/%b", n, forward_a_x, forward_b_x, exp_fwd(rs1_x), exp_fwd(rs2_x));
      end
      checks++;
      if (forward_store_m !== (mem_write_m && reg_write_w && rd_w != 0 && rs2_m == rd_w)) begin
        errors++; $display("FAIL rnd_store n=%0d got %b", n, forward_store_m);
      end
      checks++;
      if (stall_f !== exp_stall() || stall_d !== exp_stall()) begin
        errors++; $display("FAIL rnd_stall n=%0d got %b%b want %b", n, stall_f, stall_d, exp_stall());
      end
      checks++;
      if (flush_d !== pc_src_x || flush_x !== (exp_hazard() || pc_src_x)) begin
        errors++; $display("FAIL rnd_flush n=%0d got %b%b want %b%b", n, flush_d, flush_x, pc_src_x, exp_hazard() || pc_src_x);
      end
      checks++;
      if (md_busy !== md_out) begin errors++; $display("FAIL rnd_md_busy n=%0d got %b want %b", n, md_busy, md_out); end
      checks++;
      if (stall_cycles !== CW'(m_stall) || flush_count !== CW'(m_flush)) begin
        errors++; $display("FAIL rnd_cnt n=%0d got %0d/%0d want %0d/%0d", n, stall_cycles, flush_count, m_stall, m_flush);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst = 1;
    @(negedge clk);
    test_reset();
    test_forwarding();
    test_load_use();
    test_redirect();
    test_md_raw();
    test_back_to_back();
    test_saturation();
    test_reset_mid_md();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
